sb_rx_deserializer: RTL and testbench

SB_RX_DESERIALIZER -- requirements
Module: sb_rx_deserializer

---
 rtl/sb_rx_deserializer.sv | 154 +++++++++++++++
 tb/tb_sb_rx_deserializer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_rx_deserializer.sv
// Sideband RX deserializer: synchronizes the raw line, tracks connect/disconnect
// by run length, and assembles start/8-data/stop symbols into sbrx.
module sb_rx_deserializer #(
    parameter int unsigned DISC_LOW_CYCLES  = 32,
    parameter int unsigned CONN_HIGH_CYCLES = 32
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sb_rx_line,
    output logic [9:0] sbrx,
    output logic       sym_valid,
    output logic       error,
    output logic       tdisconnet,
    output logic       tconnect
);

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYM_W  = 10;

    localparam logic [BIT_W-1:0] STOP_IDX  = BIT_W'(9);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CONN_THR  = CNT_W'(CONN_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] DISC_THR  = CNT_W'(DISC_LOW_CYCLES);

    typedef enum logic [1:0] {
        ST_DISC = 2'd0,
        ST_IDLE = 2'd1,
        ST_RECV = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                rx_s_q, rx_s_d;
    logic [CNT_W-1:0]    high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]    low_cnt_q, low_cnt_d;
    logic [CNT_W-1:0]    high_inc, low_inc;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [SYM_W-1:0]    sbrx_q, sbrx_d;
    logic                sym_valid_q, sym_valid_d;
    logic                error_q, error_d;
    logic                tdisc_q, tdisc_d;
    logic                tconn_q, tconn_d;
    logic                conn_hit, disc_hit;

    // State register and all datapath flops
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_DISC;
            sync1_q     <= 1'b0;
            rx_s_q      <= 1'b0;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sbrx_q      <= '0;
            sym_valid_q <= 1'b0;
            error_q     <= 1'b0;
            tdisc_q     <= 1'b0;
            tconn_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sbrx_q      <= sbrx_d;
            sym_valid_q <= sym_valid_d;
            error_q     <= error_d;
            tdisc_q     <= tdisc_d;
            tconn_q     <= tconn_d;
        end
    end

    // Run-length counters: high runs only while disconnected, low runs only while connected
    always_comb begin
        sync1_d    = sb_rx_line;
        rx_s_d     = sync1_q;
        high_inc   = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CNT_W'(1);
        low_inc    = (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + CNT_W'(1);
        high_cnt_d = '0;
        low_cnt_d  = '0;
        conn_hit   = 1'b0;
        disc_hit   = 1'b0;
        if (state_q == ST_DISC) begin
            if (rx_s_q) begin
                if (high_inc == CONN_THR) conn_hit = 1'b1;
                else                      high_cnt_d = high_inc;
            end
        end else if (!rx_s_q) begin
            if (low_inc == DISC_THR) disc_hit = 1'b1;
            else                     low_cnt_d = low_inc;
        end
    end

    // Next-state logic; disconnect overrides any symbol activity
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISC: if (conn_hit) state_d = ST_IDLE;
            ST_IDLE: begin
                if (disc_hit)     state_d = ST_DISC;
                else if (!rx_s_q) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (disc_hit)                    state_d = ST_DISC;
                else if (bit_cnt_q == STOP_IDX)  state_d = ST_IDLE;
            end
            default: state_d = ST_DISC;
        endcase
    end

    // Symbol assembly and output pulses
    always_comb begin
        sbrx_d      = sbrx_q;
        sym_valid_d = 1'b0;
        error_d     = 1'b0;
        tdisc_d     = disc_hit;
        tconn_d     = conn_hit;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (!disc_hit && !rx_s_q) bit_cnt_d = BIT_W'(1);
            end
            ST_RECV: begin
                if (disc_hit) begin
                    bit_cnt_d = '0;
                end else if (bit_cnt_q == STOP_IDX) begin
                    sbrx_d      = {rx_s_q, shift_q, 1'b0};
                    sym_valid_d = 1'b1;
                    error_d     = ~rx_s_q;
                    bit_cnt_d   = '0;
                end else begin
                    shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            default: bit_cnt_d = '0;
        endcase
    end

    assign sbrx       = sbrx_q;
    assign sym_valid  = sym_valid_q;
    assign error      = error_q;
    assign tdisconnet = tdisc_q;
    assign tconnect   = tconn_q;

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Bench for sb_rx_deserializer: line streams scored against a run-length /
// symbol-slicing reference computed over the whole stream.
module tb_sb_rx_deserializer;

    localparam int unsigned DISC_N = 32;
    localparam int unsigned CONN_N = 32;
    localparam int          MAXN   = 2048;

    logic       sb_clk = 1'b0;
    logic       rst = 1'b0;
    logic       sb_rx_line = 1'b1;
    logic [9:0] sbrx;
    logic       sym_valid, error, tdisconnet, tconnect;

    int errors = 0;
    int checks = 0;

    bit         ln     [MAXN];
    int         n;
    bit         ev_v   [MAXN];
    bit         ev_e   [MAXN];
    bit         ev_c   [MAXN];
    bit         ev_d   [MAXN];
    logic [9:0] ev_sym [MAXN];

    always #5 sb_clk = ~sb_clk;

    sb_rx_deserializer #(
        .DISC_LOW_CYCLES  (DISC_N),
        .CONN_HIGH_CYCLES (CONN_N)
    ) dut (
        .sb_clk     (sb_clk),
        .rst        (rst),
        .sb_rx_line (sb_rx_line),
        .sbrx       (sbrx),
        .sym_valid  (sym_valid),
        .error      (error),
        .tdisconnet (tdisconnet),
        .tconnect   (tconnect)
    );

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input bit b, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            ln[n] = b;
            n++;
        end
    endtask

    task automatic push_sym(input logic [7:0] d, input bit stop);
        push_run(1'b0, 1);
        for (int i = 0; i < 8; i++) push_run(d[i], 1);
        push_run(stop, 1);
    endtask

    // First index j >= from ending a run of len samples equal to v (all inside [from..j])
    function automatic int first_run(input int from, input bit v, input int len);
        int run;
        run = 0;
        for (int j = from; j < n; j++) begin
            if (ln[j] == v) run++;
            else            run = 0;
            if (run == len) return j;
        end
        return -1;
    endfunction

    // Expected events indexed by the line sample that triggers them
    task automatic build_model();
        int i, seg, disc_at, j;
        bit up;
        logic [7:0] d;
        for (int k = 0; k < MAXN; k++) begin
            ev_v[k] = 1'b0; ev_e[k] = 1'b0; ev_c[k] = 1'b0; ev_d[k] = 1'b0; ev_sym[k] = '0;
        end
        i  = 0;
        up = 1'b0;
        while (i < n) begin
            if (!up) begin
                j = first_run(i, 1'b1, int'(CONN_N));
                if (j < 0) i = n;
                else begin
                    ev_c[j] = 1'b1;
                    up      = 1'b1;
                    i       = j + 1;
                end
            end else begin
                seg     = i;
                disc_at = first_run(seg, 1'b0, int'(DISC_N));
                if (disc_at < 0) disc_at = n + 100;
                while (i < disc_at && i < n) begin
                    if (ln[i]) i++;
                    else if (i + 9 < disc_at && i + 9 < n) begin
                        for (int b = 0; b < 8; b++) d[b] = ln[i + 1 + b];
                        ev_v[i + 9]   = 1'b1;
                        ev_e[i + 9]   = !ln[i + 9];
                        ev_sym[i + 9] = {ln[i + 9], d, 1'b0};
                        i = i + 10;
                    end else i = disc_at;
                end
                if (disc_at < n) begin
                    ev_d[disc_at] = 1'b1;
                    up            = 1'b0;
                    i             = disc_at + 1;
                end else i = n;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sbrx"}, sbrx, 10'h000);
        chk({tag, "_valid"}, 10'(sym_valid), 10'd0);
        chk({tag, "_error"}, 10'(error), 10'd0);
        chk({tag, "_tdisc"}, 10'(tdisconnet), 10'd0);
        chk({tag, "_tconn"}, 10'(tconnect), 10'd0);
    endtask

    // Reset, release, play ln[0..n-1]; outputs after edge k reflect line sample k-2
    task automatic run_phase(input string name, input int abort_at);
        logic [9:0] cur;
        int s;
        bit ev, ee, ec, ed;
        build_model();
        @(negedge sb_clk);
        rst = 1'b0;
        #1;
        chk_all_zero({name, "_reset"});
        @(negedge sb_clk);
        rst = 1'b1;
        cur = '0;
        for (int k = 0; k < n; k++) begin
            sb_rx_line = ln[k];
            @(posedge sb_clk);
            #1;
            s  = k - 2;
            ev = (s >= 0) ? ev_v[s] : 1'b0;
            ee = (s >= 0) ? ev_e[s] : 1'b0;
            ec = (s >= 0) ? ev_c[s] : 1'b0;
            ed = (s >= 0) ? ev_d[s] : 1'b0;
            if (ev) cur = ev_sym[s];
            chk({name, "_sym_valid"}, 10'(sym_valid), 10'(ev));
            chk({name, "_error"}, 10'(error), 10'(ee));
            chk({name, "_tconnect"}, 10'(tconnect), 10'(ec));
            chk({name, "_tdisconnet"}, 10'(tdisconnet), 10'(ed));
            chk({name, "_sbrx"}, sbrx, cur);
            if (k == abort_at) begin
                #2;
                rst = 1'b0;
                #1;
                chk_all_zero({name, "_abort"});
                return;
            end
        end
    endtask

    initial begin
        int gap;
        int bit5_idx;
        logic [7:0] d;

        // Connect, directed symbols, framing error, random traffic, disconnect/reconnect
        n = 0;
        push_run(1'b1, 40);
        push_sym(8'hFE, 1'b1);
        push_run(1'b1, 3);
        push_sym(8'hFE, 1'b1);
        push_sym(8'h05, 1'b1);
        push_sym(8'h40, 1'b1);
        push_sym(8'h40, 1'b0);
        push_run(1'b1, 1);
        push_sym(8'hA5, 1'b1);
        for (int r = 0; r < 24; r++) begin
            gap = int'($urandom_range(0, 3));
            d   = 8'($urandom);
            push_run(1'b1, gap);
            push_sym(d, ($urandom_range(0, 7) != 0));
        end
        push_run(1'b1, 2);
        push_run(1'b0, 40);
        push_sym(8'hFE, 1'b1);
        push_run(1'b1, 40);
        push_sym(8'h3C, 1'b1);
        // Thirty-second low sample lands exactly on a stop bit
        push_run(1'b1, 2);
        push_sym(8'h40, 1'b0);
        push_sym(8'h00, 1'b0);
        push_sym(8'h00, 1'b0);
        push_sym(8'h00, 1'b0);
        push_run(1'b1, 40);
        push_sym(8'h81, 1'b1);
        push_run(1'b1, 4);
        run_phase("main", -1);

        // No connect yet: symbols right after reset are ignored
        n = 0;
        push_run(1'b1, 5);
        push_sym(8'hFE, 1'b1);
        push_run(1'b1, 20);
        push_run(1'b0, 1);
        push_run(1'b1, 36);
        push_sym(8'h5A, 1'b1);
        push_run(1'b1, 4);
        run_phase("preconn", -1);

        // Reset while bit 5 of a symbol is being received
        n = 0;
        push_run(1'b1, 36);
        push_sym(8'hC3, 1'b1);
        push_run(1'b1, 2);
        push_run(1'b0, 1);
        push_run(1'b1, 1); push_run(1'b0, 1); push_run(1'b1, 1);
        push_run(1'b1, 1); push_run(1'b0, 1);
        bit5_idx = n;
        push_run(1'b1, 1);
        push_run(1'b0, 1); push_run(1'b1, 1); push_run(1'b1, 1);
        push_run(1'b1, 6);
        run_phase("abort", bit5_idx + 2);

        // After abort: symbol ignored until connect, then traffic resumes
        n = 0;
        push_run(1'b1, 2);
        push_sym(8'hFE, 1'b1);
        push_run(1'b1, 34);
        for (int r = 0; r < 8; r++) begin
            d = 8'($urandom);
            push_sym(d, 1'b1);
        end
        push_run(1'b1, 4);
        run_phase("postabort", -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
